// File: rtl/etpu_result_collector_if.sv
// Wishbone classic slave bus used by the eTPU result collector.
// Signal names follow the slave's point of view (_i = into the slave).
interface etpu_result_collector_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    // Bus master (the Caravel CPU side, or a testbench driver)
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    // Bus slave (the collector)
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/etpu_result_collector.sv
// eTPU result collector: captures tagged 16-bit results into a small FIFO
// and lets the CPU drain them through a 16-byte Wishbone register window.
//   0x0 POP    (R)  {valid, 11'b0, tag[3:0], data[15:0]}, pops the head
//   0x4 STATUS (R)  {overflow, 23'b0, count[7:0]}
//   0x8 CTRL   (RW) bit0 cap_en, bit1 flush (write-1 pulse), bit2 irq_en
//   0xC DROPS  (R)  {16'b0, drop_cnt[15:0]}
module etpu_result_collector #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         en_i,
    input  logic [15:0]                  out1_i,
    input  logic [3:0]                   load_end_i,
    etpu_result_collector_if.slave       wbs,
    output logic                         irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        REG_POP    = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_DROPS  = 2'd3
    } reg_off_e;

    // FIFO storage: {tag, data}
    logic [19:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             cap_en_q, cap_en_d;
    logic             irq_en_q, irq_en_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             irq_q, irq_d;

    // Decoded bus request and FIFO events for the current cycle
    reg_off_e         reg_off;
    logic             req;
    logic             rd_req;
    logic             ctrl_wr;
    logic             flush;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             capture;
    logic             push;
    logic             drop;

    // Address bits, data lanes and byte selects that no register uses
    logic             unused_bits;
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:3], wbs.wbs_sel_i[3:1]};

    // Request decode and FIFO event generation
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned, which would infer a latch.
        reg_off    = reg_off_e'(wbs.wbs_adr_i[3:2]);
        req        = wbs.wbs_stb_i && wbs.wbs_cyc_i && !ack_q &&
                     (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        rd_req     = req && !wbs.wbs_we_i;
        // All CTRL bits live in byte lane 0
        ctrl_wr    = req && wbs.wbs_we_i && (reg_off == REG_CTRL) && wbs.wbs_sel_i[0];
        flush      = ctrl_wr && wbs.wbs_dat_i[1];
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        pop        = rd_req && (reg_off == REG_POP) && !fifo_empty;
        // cap_en_q is the pre-write value, so a CTRL write acts from the next edge
        capture    = en_i && cap_en_q && !flush;
        // A pop on the same edge frees the slot, so a full FIFO still accepts
        push       = capture && (!fifo_full || pop);
        drop       = capture && fifo_full && !pop;
    end

    // Next-state for FIFO pointers, occupancy and overflow bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Next-state for CTRL fields
    always_comb begin
        cap_en_d = cap_en_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            cap_en_d = wbs.wbs_dat_i[0];
            irq_en_d = wbs.wbs_dat_i[2];
        end
    end

    // Bus response: ack and read data for the access seen this cycle
    always_comb begin
        ack_d = req;
        dat_d = '0;
        if (rd_req) begin
            case (reg_off)
                REG_POP:    dat_d = fifo_empty ? 32'h0 : {1'b1, 11'b0, mem_q[rd_ptr_q]};
                REG_STATUS: dat_d = {overflow_q, 23'b0, 8'(count_q)};
                REG_CTRL:   dat_d = {29'b0, irq_en_q, 1'b0, cap_en_q};
                REG_DROPS:  dat_d = {16'b0, drop_cnt_q};
                default:    dat_d = '0;
            endcase
        end
    end

    // Interrupt level, one cycle behind the state it reports
    always_comb begin
        irq_d = irq_en_q && (!fifo_empty || overflow_q);
    end

    // State registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            cap_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            cap_en_q   <= cap_en_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    // FIFO storage write
    // NOTE: storage is not reset; occupancy is tracked by count_q, so stale contents are never visible.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {load_end_i, out1_i};
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_etpu_result_collector.sv
// Directed bench for etpu_result_collector. A queue-based model tracks what
// the block must answer; a negedge process compares every cycle, and the
// directed sequence pins the model with hand-computed literal values.
module tb_etpu_result_collector;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] out1;
    logic [3:0]  tag;
    logic        irq;

    int total = 0;
    int bad   = 0;

    etpu_result_collector_if wb ();

    etpu_result_collector #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .en_i       (en),
        .out1_i     (out1),
        .load_end_i (tag),
        .wbs        (wb.slave),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [19:0] mq[$];
    logic        m_ovf, m_cap, m_irqen;
    logic [15:0] m_drops;
    logic        e_ack, e_irq;
    logic [31:0] e_dat;

    always @(posedge clk or posedge rst) begin
        int   size0;
        logic req, popped, flush, capture;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_cap = 0; m_irqen = 0; m_drops = 0;
            e_ack = 0; e_irq = 0; e_dat = 0;
        end else begin
            size0   = mq.size();
            req     = wb.wbs_stb_i && wb.wbs_cyc_i && !e_ack &&
                      (wb.wbs_adr_i[31:4] == BASE[31:4]);
            capture = en && m_cap;
            popped  = 0;
            flush   = 0;
            e_irq   = m_irqen && (size0 != 0 || m_ovf);
            e_ack   = req;
            e_dat   = 0;
            if (req && !wb.wbs_we_i) begin
                case (wb.wbs_adr_i[3:2])
                    2'd0: if (size0 != 0) begin
                        e_dat = {1'b1, 11'b0, mq[0]};
                        void'(mq.pop_front());
                        popped = 1;
                    end
                    2'd1: e_dat = {m_ovf, 23'b0, 8'(size0)};
                    2'd2: e_dat = {29'b0, m_irqen, 1'b0, m_cap};
                    default: e_dat = {16'b0, m_drops};
                endcase
            end
            if (req && wb.wbs_we_i && wb.wbs_adr_i[3:2] == 2'd2 && wb.wbs_sel_i[0]) begin
                flush   = wb.wbs_dat_i[1];
                m_cap   = wb.wbs_dat_i[0];
                m_irqen = wb.wbs_dat_i[2];
            end
            if (flush) begin
                mq.delete();
                m_ovf = 0;
                m_drops = 0;
            end else if (capture) begin
                if (size0 < DEPTH || popped) mq.push_back({tag, out1});
                else begin
                    m_ovf = 1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("ack",   {31'b0, wb.wbs_ack_o}, {31'b0, e_ack});
            check("rdata", wb.wbs_dat_o, e_dat);
            check("irq",   {31'b0, irq}, {31'b0, e_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] sel, input logic cap, input logic [15:0] cd,
                             input logic [3:0] ct, input logic exp_ack,
                             output logic [31:0] rdat, output logic irq_at);
        logic got;
        got = 0; rdat = 0; irq_at = 0;
        @(negedge clk);
        wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr; wb.wbs_dat_i = wdat; wb.wbs_sel_i = sel;
        if (cap) begin en = 1; out1 = cd; tag = ct; end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            en = 0;
            if (wb.wbs_ack_o) begin
                got = 1; rdat = wb.wbs_dat_o; irq_at = irq;
                break;
            end
        end
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
        check(exp_ack ? "ack_seen" : "no_ack", {31'b0, got}, {31'b0, exp_ack});
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        logic ia;
        wb_access(1'b0, BASE + 32'(off), 32'h0, 4'hF, 1'b0, 16'h0, 4'h0, 1'b1, d, ia);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] v, input logic [3:0] sel);
        logic [31:0] d;
        logic        ia;
        wb_access(1'b1, BASE + 32'(off), v, sel, 1'b0, 16'h0, 4'h0, 1'b1, d, ia);
    endtask

    task automatic cap_word(input logic [15:0] d, input logic [3:0] t);
        @(negedge clk);
        en = 1; out1 = d; tag = t;
    endtask

    task automatic cap_stop();
        @(negedge clk);
        en = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        logic        ia;
        rst = 1; en = 0; out1 = 0; tag = 0;
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
        wb.wbs_sel_i = 0; wb.wbs_dat_i = 0; wb.wbs_adr_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // Reset state
        check("irq_rst", {31'b0, irq}, 32'h0);
        rd(4'h0, d); check("pop_rst",    d, 32'h0);
        rd(4'h4, d); check("status_rst", d, 32'h0);
        rd(4'h8, d); check("ctrl_rst",   d, 32'h0);
        rd(4'hC, d); check("drops_rst",  d, 32'h0);

        // Three tagged captures
        wr(4'h8, 32'h1, 4'hF);
        cap_word(16'h1111, 4'h1);
        cap_word(16'h2222, 4'h2);
        cap_word(16'h3333, 4'hF);
        cap_stop();
        rd(4'h4, d); check("status3", d, 32'h0000_0003);
        rd(4'h0, d); check("pop1", d, 32'h8001_1111);
        rd(4'h0, d); check("pop2", d, 32'h8002_2222);
        rd(4'h0, d); check("pop3", d, 32'h800F_3333);
        rd(4'h0, d); check("pop_empty", d, 32'h0);

        // Overfill: 11 captures into 8 entries
        for (int i = 0; i < 11; i++) cap_word(16'hA000 + 16'(i), 4'(i));
        cap_stop();
        rd(4'h4, d); check("status_full", d, 32'h8000_0008);
        rd(4'hC, d); check("drops3", d, 32'h0000_0003);

        // POP and capture on the same edge while full
        wb_access(1'b0, BASE, 32'h0, 4'hF, 1'b1, 16'hBEEF, 4'hC, 1'b1, d, ia);
        check("pop_full_cap", d, 32'h8000_A000);
        rd(4'h4, d); check("status_still8", d, 32'h8000_0008);
        rd(4'hC, d); check("drops_still3", d, 32'h0000_0003);
        for (int i = 1; i < 8; i++) begin
            rd(4'h0, d);
            check("pop_order", d, 32'h8000_0000 | (32'(i) << 16) | (32'hA000 + 32'(i)));
        end
        rd(4'h0, d); check("pop_newest", d, 32'h800C_BEEF);
        rd(4'h0, d); check("pop_empty2", d, 32'h0);

        // Flush with five words held
        for (int i = 0; i < 5; i++) cap_word(16'h5000 + 16'(i), 4'(i));
        cap_stop();
        rd(4'h4, d); check("status5", d, 32'h8000_0005);
        wr(4'h8, 32'h3, 4'hF);
        rd(4'h4, d); check("status_flush", d, 32'h0);
        rd(4'hC, d); check("drops_flush", d, 32'h0);
        rd(4'h8, d); check("ctrl_flush_rd", d, 32'h0000_0001);
        cap_word(16'h5555, 4'h5);
        cap_stop();
        rd(4'h0, d); check("head_after_flush", d, 32'h8005_5555);

        // Flush coinciding with a capture: capture discarded, not a drop
        cap_word(16'h6001, 4'h6);
        cap_word(16'h6002, 4'h6);
        cap_stop();
        wb_access(1'b1, BASE + 32'h8, 32'h3, 4'hF, 1'b1, 16'h7777, 4'h7, 1'b1, d, ia);
        rd(4'h4, d); check("status_flush_cap", d, 32'h0);
        rd(4'hC, d); check("drops_flush_cap", d, 32'h0);

        // Byte-lane gating, read-only writes, out-of-window access
        wr(4'h8, 32'h4, 4'h0);
        rd(4'h8, d); check("ctrl_sel0", d, 32'h0000_0001);
        wr(4'h4, 32'hFFFF_FFFF, 4'hF);
        rd(4'h4, d); check("status_ro", d, 32'h0);
        wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 16'h0, 4'h0, 1'b0, d, ia);

        // Interrupt
        wr(4'h8, 32'h5, 4'hF);
        @(posedge clk); #1;
        check("irq_idle", {31'b0, irq}, 32'h0);
        cap_word(16'h9999, 4'h9);
        cap_stop();
        @(posedge clk); #1;
        check("irq_rise", {31'b0, irq}, 32'h1);
        wb_access(1'b0, BASE, 32'h0, 4'hF, 1'b0, 16'h0, 4'h0, 1'b1, d, ia);
        check("pop_irq", d, 32'h8009_9999);
        check("irq_at_ack", {31'b0, ia}, 32'h1);
        check("irq_fall", {31'b0, irq}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/etpu_result_collector.md
# etpu_result_collector

Downstream capture stage for the eTPU array. It samples the 16-bit result bus (`out1`), the 4-bit `load_end` tag and the `en` strobe produced by `edu_tpu`, and buffers tagged results in a small FIFO. The Caravel CPU drains the FIFO over the Wishbone slave port, so results survive even when the CPU polls slowly. It shares the wrapper's Wishbone bus and decodes its own 16-byte window.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `BASE_ADDR`, 32'h3000_0100: register window base; bits [3:0] ignored.

Ports:
- Clock and reset (already decided): one clock, reset is asynchronous and active-high.
- `wb_clk_i` in 1: system clock; the only clock.
- `wb_rst_i` in 1: reset, asynchronous assert, active-high.
- `en_i` in 1: result-valid strobe from eTPU (`en`).
- `out1_i` in 16: result word from eTPU (`out1`).
- `load_end_i` in 4: tag from eTPU (`load_end`), stored with each word.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i` in 4: byte selects; writes act only on lanes with sel=1.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: byte address.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data; 0 whenever `wbs_ack_o`=0.
- `irq_o` out 1: registered level interrupt.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x0 POP (R): returns {valid[31], 11'b0, tag[19:16], data[15:0]} of the head entry and pops it. If the FIFO is empty it returns 0 and does not pop.
  - 0x4 STATUS (R): {overflow[31], 23'b0, count[7:0]}.
  - 0x8 CTRL (RW): bit0 `cap_en`, bit2 `irq_en`. Bit1 is `flush`: write-1 self-clearing, always reads 0.
  - 0xC DROPS (R): {16'b0, drop_cnt[15:0]}.
  - Writes to read-only offsets are acked and ignored.
- Address decode: the block responds only when `wbs_adr_i[31:4]` equals `BASE_ADDR[31:4]`. Outside the window it never acks.
- Capture: on each edge where `en_i`=1 and `cap_en`=1:
  - If not full, push {`load_end_i`, `out1_i`}.
  - If full, the word is discarded, `overflow` is set (sticky), and `drop_cnt` increments, saturating at 16'hFFFF.
- Simultaneous push and POP on the same edge: both take effect and count is unchanged. This holds even when the FIFO is full, in which case the push is accepted and nothing is dropped. Empty-state rules still apply to the pop.
- Flush (CTRL bit1 written 1): on that edge count→0, read/write pointers→0, `overflow`→0, `drop_cnt`→0. A capture on the same edge is discarded but not counted as a drop.
- Pointers wrap modulo `DEPTH`. Count ranges 0..`DEPTH`.
- `irq_o` = `irq_en` & (count≠0 | `overflow`), registered with one cycle of lag.
- Reset: FIFO empty, pointers 0, `cap_en`=0, `irq_en`=0, `overflow`=0, `drop_cnt`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0. FIFO storage contents are don't-care.
- Reset mid-transaction: the ack is aborted, and the pending POP is lost without popping.

## Timing
- Request seen in cycle N (`stb`&`cyc`&decode&!`ack`). At the edge ending N:
  - `wbs_ack_o`=1 and `wbs_dat_o` is loaded.
  - The pop or register write commits.
- `wbs_ack_o` is high for exactly one cycle, then 0 for at least one cycle. Maximum throughput is one access per 2 cycles.
- POP data reflects FIFO state at the start of cycle N. A push on the same edge is not visible, so an empty FIFO returns valid=0.
- Capture latency: with `en_i` high in cycle N, STATUS reflects the entry for a request issued in cycle N+1 or later.
- A CTRL write of `cap_en`=1 affects captures from the following edge onward.

## Test plan
- Reset, then read all four offsets → POP=0, STATUS=0, CTRL=0, DROPS=0; `irq_o`=0.
- `cap_en`=1; pulse `en_i` 3 cycles with data 0x1111/0x2222/0x3333 and tag 0x1/0x2/0xF. Then:
  - STATUS=3.
  - POPs return 0x8001_1111, 0x8002_2222, 0x800F_3333.
  - A 4th POP returns 0.
- `DEPTH`=8, hold `en_i` high 11 cycles → STATUS=0x8000_0008, DROPS=3. POP returns the first 8 words in order.
- With the FIFO full, issue a POP on the same edge as a capture → no drop, count stays 8, the newest word is stored last.
- `irq_en`=1, push 1 word → `irq_o` rises; POP the word → `irq_o` falls one cycle after ack.
- With the FIFO holding 5 words, write CTRL=0x3 (flush, `cap_en` kept) → STATUS=0, DROPS=0, and a subsequent capture becomes the head.
